// File: rtl/ras_ctrl.sv
// Return-address-stack controller: enable/invalidate sequencing, misprediction-driven
// suspension with cooldown, and RAS-vs-BTB prediction arbitration.
module ras_ctrl #(
  parameter int unsigned MISS_TH  = 3,
  parameter int unsigned COOLDOWN = 64
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_cfg_en_i,
  input  logic        s_fencei_i,
  input  logic        s_flush_i,
  input  logic        s_mispred_i,
  input  logic        s_hit_i,
  input  logic [1:0]  s_ras_poped_i,
  input  logic [30:0] s_ras_addr_i,
  input  logic [1:0]  s_btb_pred_i,
  input  logic [30:0] s_btb_addr_i,
  output logic        s_ras_enable_o,
  output logic        s_ras_invalidate_o,
  output logic [1:0]  s_pred_o,
  output logic [30:0] s_pred_addr_o,
  output logic        s_pred_src_o,
  output logic [15:0] s_suspend_cnt_o
);

  localparam int unsigned MISS_W = 4;
  localparam int unsigned COOL_W = 10;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 31;

  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_TH - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_INVAL   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_SUSPEND = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [COOL_W-1:0]   cool_q, cool_d;
  logic [CNT_W-1:0]    suspend_cnt_q, suspend_cnt_d;

  // State and counter registers
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q       <= ST_OFF;
      miss_q        <= '0;
      cool_q        <= '0;
      suspend_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_q        <= miss_d;
      cool_q        <= cool_d;
      suspend_cnt_q <= suspend_cnt_d;
    end
  end

  // Next-state: fence.i beats disable, which beats the per-state rules
  always_comb begin
    state_d       = state_q;
    miss_d        = miss_q;
    cool_d        = cool_q;
    suspend_cnt_d = suspend_cnt_q;

    if (s_fencei_i) begin
      state_d = ST_INVAL;
    end else if (!s_cfg_en_i) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF:   state_d = ST_INVAL;
        ST_INVAL: state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (s_mispred_i) begin
            if (miss_q >= MISS_LAST) begin
              state_d = ST_SUSPEND;
              miss_d  = '0;
              cool_d  = COOL_LOAD;
              if (suspend_cnt_q != {CNT_W{1'b1}}) begin
                suspend_cnt_d = suspend_cnt_q + CNT_W'(1);
              end
            end else if (miss_q != {MISS_W{1'b1}}) begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else if (s_hit_i) begin
            miss_d = '0;
          end
        end
        ST_SUSPEND: begin
          if (cool_q == '0) begin
            state_d = ST_INVAL;
          end else begin
            cool_d = cool_q - COOL_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Miss history never survives a disable or invalidate
    if (state_d == ST_INVAL || state_d == ST_OFF) begin
      miss_d = '0;
    end
  end

  assign s_ras_invalidate_o = (state_q == ST_INVAL);
  assign s_ras_enable_o     = (state_q == ST_ACTIVE);
  assign s_suspend_cnt_o    = suspend_cnt_q;

  logic [1:0] ras_flags;
  assign ras_flags = (state_q == ST_ACTIVE) ? s_ras_poped_i : 2'b00;

  // Earliest slot wins; RAS takes ties
  always_comb begin
    s_pred_o      = 2'b00;
    s_pred_addr_o = '0;
    s_pred_src_o  = 1'b0;
    if (!s_flush_i) begin
      if (ras_flags[0]) begin
        s_pred_o      = 2'b01;
        s_pred_addr_o = s_ras_addr_i;
        s_pred_src_o  = 1'b1;
      end else if (s_btb_pred_i[0]) begin
        s_pred_o      = 2'b01;
        s_pred_addr_o = s_btb_addr_i;
      end else if (ras_flags[1]) begin
        s_pred_o      = 2'b10;
        s_pred_addr_o = s_ras_addr_i;
        s_pred_src_o  = 1'b1;
      end else if (s_btb_pred_i[1]) begin
        s_pred_o      = 2'b10;
        s_pred_addr_o = s_btb_addr_i;
      end else begin
        s_pred_addr_o = ADDR_W'(0);
      end
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl (MISS_TH=3, COOLDOWN=4): sequencing, suspension,
// priority, arbitration, reset abort and counter saturation.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_en, fencei, flush, mispred, hit;
  logic [1:0]  ras_poped, btb_pred;
  logic [30:0] ras_addr, btb_addr;
  logic        ras_enable, ras_invalidate, pred_src;
  logic [1:0]  pred;
  logic [30:0] pred_addr;
  logic [15:0] suspend_cnt;

  int errors = 0;
  int checks = 0;

  ras_ctrl #(.MISS_TH(3), .COOLDOWN(4)) dut (
    .s_clk_i            (clk),
    .s_resetn_i         (resetn),
    .s_cfg_en_i         (cfg_en),
    .s_fencei_i         (fencei),
    .s_flush_i          (flush),
    .s_mispred_i        (mispred),
    .s_hit_i            (hit),
    .s_ras_poped_i      (ras_poped),
    .s_ras_addr_i       (ras_addr),
    .s_btb_pred_i       (btb_pred),
    .s_btb_addr_i       (btb_addr),
    .s_ras_enable_o     (ras_enable),
    .s_ras_invalidate_o (ras_invalidate),
    .s_pred_o           (pred),
    .s_pred_addr_o      (pred_addr),
    .s_pred_src_o       (pred_src),
    .s_suspend_cnt_o    (suspend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fsm(input string tag, input logic en, input logic inv);
    chk({tag, ".en"}, 32'(ras_enable), 32'(en));
    chk({tag, ".inv"}, 32'(ras_invalidate), 32'(inv));
  endtask

  task automatic chk_pred(input string tag, input logic [1:0] p, input logic src,
                          input logic [30:0] a);
    #1;
    chk({tag, ".pred"}, 32'(pred), 32'(p));
    chk({tag, ".src"}, 32'(pred_src), 32'(src));
    chk({tag, ".addr"}, 32'(pred_addr), 32'(a));
  endtask

  localparam logic [30:0] RA = 31'h1234_5678;
  localparam logic [30:0] BA = 31'h0ABC_DEF1;

  initial begin
    resetn = 1'b0; cfg_en = 1'b0; fencei = 1'b0; flush = 1'b0;
    mispred = 1'b0; hit = 1'b0; ras_poped = 2'b00; btb_pred = 2'b00;
    ras_addr = RA; btb_addr = BA;
    tick(); tick();
    chk_fsm("reset", 1'b0, 1'b0);
    chk("reset.cnt", 32'(suspend_cnt), 32'h0);

    // Enable: OFF for the release cycle, one INVAL, then ACTIVE steady
    resetn = 1'b1; cfg_en = 1'b1;
    #1 chk_fsm("en.off", 1'b0, 1'b0);
    tick(); chk_fsm("en.inval", 1'b0, 1'b1);
    tick(); chk_fsm("en.active", 1'b1, 1'b0);
    tick(); chk_fsm("en.steady", 1'b1, 1'b0);

    // Suspension after three misses, lasting four cycles
    mispred = 1'b1;
    tick(); chk_fsm("miss1", 1'b1, 1'b0);
    tick(); chk_fsm("miss2", 1'b1, 1'b0);
    tick();
    mispred = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_fsm($sformatf("susp%0d", i), 1'b0, 1'b0);
      tick();
    end
    chk_fsm("susp.inval", 1'b0, 1'b1);
    chk("susp.cnt", 32'(suspend_cnt), 32'h1);
    tick(); chk_fsm("susp.reen", 1'b1, 1'b0);

    // Hit clears the miss counter
    mispred = 1'b1; tick(); tick();
    mispred = 1'b0; hit = 1'b1; tick();
    mispred = 1'b1; hit = 1'b0; tick();
    chk_fsm("clear.nosusp", 1'b1, 1'b0);
    chk("clear.cnt", 32'(suspend_cnt), 32'h1);
    // Simultaneous mispred+hit counts as a miss: miss goes 1 -> 2 -> 3
    hit = 1'b1; tick();
    hit = 1'b0; tick();
    mispred = 1'b0;
    chk_fsm("both.susp", 1'b0, 1'b0);
    chk("both.cnt", 32'(suspend_cnt), 32'h2);

    // fence.i during SUSPEND cuts it short
    tick();
    fencei = 1'b1; tick(); chk_fsm("fence.susp.inval", 1'b0, 1'b1);
    fencei = 1'b0; tick(); chk_fsm("fence.susp.active", 1'b1, 1'b0);

    // Arbitration in ACTIVE
    ras_poped = 2'b10; btb_pred = 2'b01; chk_pred("arb.btb_early", 2'b01, 1'b0, BA);
    ras_poped = 2'b01; btb_pred = 2'b01; chk_pred("arb.tie", 2'b01, 1'b1, RA);
    flush = 1'b1;                        chk_pred("arb.flush", 2'b00, 1'b0, 31'h0);
    ras_poped = 2'b10; btb_pred = 2'b01; chk_pred("arb.flush2", 2'b00, 1'b0, 31'h0);
    flush = 1'b0;
    ras_poped = 2'b11; btb_pred = 2'b10; chk_pred("arb.ras_low", 2'b01, 1'b1, RA);
    ras_poped = 2'b10; btb_pred = 2'b10; chk_pred("arb.tie1", 2'b10, 1'b1, RA);
    ras_poped = 2'b00; btb_pred = 2'b11; chk_pred("arb.btb_only", 2'b01, 1'b0, BA);
    ras_poped = 2'b00; btb_pred = 2'b00; chk_pred("arb.none", 2'b00, 1'b0, 31'h0);

    // Two misses, then disable: history must be dropped
    mispred = 1'b1; tick(); tick();
    cfg_en = 1'b0; tick();
    mispred = 1'b0;
    chk_fsm("off", 1'b0, 1'b0);
    ras_poped = 2'b01; btb_pred = 2'b10; chk_pred("arb.off_ignore_ras", 2'b10, 1'b0, BA);
    ras_poped = 2'b00; btb_pred = 2'b00;

    // fence.i with enable low: INVAL, then back to OFF
    fencei = 1'b1; tick(); chk_fsm("fence.off.inval", 1'b0, 1'b1);
    fencei = 1'b0; tick(); chk_fsm("fence.off.off", 1'b0, 1'b0);
    tick(); chk_fsm("fence.off.stay", 1'b0, 1'b0);

    // Re-enable: needs three fresh misses
    cfg_en = 1'b1; tick(); tick();
    chk_fsm("reen.active", 1'b1, 1'b0);
    mispred = 1'b1;
    tick(); tick();
    chk_fsm("reen.two_miss", 1'b1, 1'b0);
    tick();
    mispred = 1'b0;
    chk_fsm("reen.susp", 1'b0, 1'b0);
    chk("reen.cnt", 32'(suspend_cnt), 32'h3);

    // Reset mid-SUSPEND aborts it with no invalidate pulse
    tick();
    resetn = 1'b0; tick();
    chk_fsm("rst.susp", 1'b0, 1'b0);
    chk("rst.cnt", 32'(suspend_cnt), 32'h0);
    tick(); tick(); tick();
    chk_fsm("rst.hold", 1'b0, 1'b0);
    resetn = 1'b1;
    #1 chk_fsm("rst.off", 1'b0, 1'b0);
    tick(); chk_fsm("rst.inval", 1'b0, 1'b1);
    tick(); chk_fsm("rst.active", 1'b1, 1'b0);

    // Saturation: preload near the top, then suspend twice
    force dut.suspend_cnt_q = 16'hFFFE;
    tick();
    release dut.suspend_cnt_q;
    #1 chk("sat.preload", 32'(suspend_cnt), 32'hFFFE);
    mispred = 1'b1; tick(); tick(); tick();
    mispred = 1'b0;
    chk("sat.top", 32'(suspend_cnt), 32'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk_fsm("sat.reen", 1'b1, 1'b0);
    mispred = 1'b1; tick(); tick(); tick();
    mispred = 1'b0;
    chk_fsm("sat.susp", 1'b0, 1'b0);
    chk("sat.hold", 32'(suspend_cnt), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter MISS_TH, default 3: consecutive RAS mispredictions that trigger suspension; legal range 1..15.
REQ-002 Parameter COOLDOWN, default 64: suspension length in cycles; legal range 1..1024.
REQ-003 The clock is s_clk_i; reset is s_resetn_i, synchronous and active-low.
REQ-004 s_clk_i  in  1  clock.
REQ-005 s_resetn_i  in  1  synchronous active-low reset.
REQ-006 s_cfg_en_i  in  1  CSR enable for return-address prediction.
REQ-007 s_fencei_i  in  1  one-cycle request to invalidate all RAS entries.
REQ-008 s_flush_i  in  1  front-end flush; suppresses predictions this cycle.
REQ-009 s_mispred_i  in  1  executed control transfer that the RAS predicted was mispredicted.
REQ-010 s_hit_i  in  1  executed control transfer that the RAS predicted was confirmed correct.
REQ-011 s_ras_poped_i  in  2  RAS pop flags; [0] is the aligned slot, [1] the unaligned slot.
REQ-012 s_ras_addr_i  in  31  RAS target, as {word address, halfword bit}.
REQ-013 s_btb_pred_i  in  2  BTB prediction flags, same slot encoding as s_ras_poped_i.
REQ-014 s_btb_addr_i  in  31  BTB target.
REQ-015 s_ras_enable_o  out  1  drives the RAS enable.
REQ-016 s_ras_invalidate_o  out  1  drives the RAS invalidate.
REQ-017 s_pred_o  out  2  arbitrated prediction flags; one-hot or zero.
REQ-018 s_pred_addr_o  out  31  arbitrated target.
REQ-019 s_pred_src_o  out  1  prediction source; 1 = RAS, 0 = BTB.
REQ-020 s_suspend_cnt_o  out  16  saturating count of suspensions, readable by CSR.

Function
REQ-021 The FSM SHALL have four states: OFF, INVAL, ACTIVE and SUSPEND.
REQ-022 Transition priority, evaluated each cycle:
 - s_fencei_i -> INVAL;
 - else !s_cfg_en_i -> OFF;
 - else the state-specific rules in REQ-023..REQ-026.
REQ-023 OFF -> INVAL when s_cfg_en_i=1.
REQ-024 INVAL SHALL last exactly one cycle, then go to ACTIVE.
REQ-025 ACTIVE: the miss counter increments on s_mispred_i and clears on s_hit_i; if both are asserted, s_mispred_i wins; the counter never wraps.
REQ-026 ACTIVE -> SUSPEND on the s_mispred_i that brings the miss counter to MISS_TH; in that same cycle the miss counter clears and the cooldown counter loads COOLDOWN-1.
REQ-027 SUSPEND: the cooldown counter decrements each cycle; when it reads 0, go to INVAL (stale entries are purged before re-enable). SUSPEND therefore lasts exactly COOLDOWN cycles.
REQ-028 The miss counter SHALL clear on every entry into INVAL or OFF; s_mispred_i and s_hit_i SHALL be ignored outside ACTIVE.
REQ-029 Outputs decoded from registered state:
 - s_ras_invalidate_o = (state==INVAL);
 - s_ras_enable_o = (state==ACTIVE).
REQ-030 s_suspend_cnt_o SHALL increment on each ACTIVE->SUSPEND transition and saturate at 16'hFFFF.
REQ-031 Arbitration (combinational):
 - RAS flags are considered only in ACTIVE; otherwise they are treated as 2'b00.
 - The source whose lowest set slot bit is lower (earlier in program order) wins.
 - On an equal slot, RAS wins.
 - s_pred_o carries only the winner's lowest set bit.
REQ-032 With no candidate, or with s_flush_i=1: s_pred_o=2'b00, s_pred_addr_o=0, s_pred_src_o=0.
REQ-033 s_pred_addr_o SHALL be the winner's address, passed through unmodified.

Reset
REQ-034 While s_resetn_i=0 at a clock edge:
 - state=OFF; miss and cooldown counters=0; s_suspend_cnt_o=0;
 - s_ras_enable_o=0 and s_ras_invalidate_o=0 from the next cycle.
REQ-035 Reset asserted mid-SUSPEND or mid-INVAL SHALL abort the operation; no invalidate pulse is issued for the aborted operation.
REQ-036 The first cycle after reset release with s_cfg_en_i=1 SHALL be OFF; INVAL follows on the next cycle.

Verification
REQ-037 Enable: reset, then s_cfg_en_i=1 -> exactly one cycle of s_ras_invalidate_o=1, then s_ras_enable_o=1 steady.
REQ-038 Suspension (MISS_TH=3, COOLDOWN=4): three s_mispred_i pulses in ACTIVE -> enable drops the next cycle, stays low for 4 cycles, then a 1-cycle invalidate, then enable=1; s_suspend_cnt_o=1.
REQ-039 Counter clear: mispred, mispred, hit, mispred -> no suspension; mispred and hit in the same cycle count as a miss.
REQ-040 Arbitration: RAS 2'b10 with BTB 2'b01 -> s_pred_o=2'b01, src=0, BTB address. RAS 2'b01 with BTB 2'b01 -> src=1, RAS address. Either case with s_flush_i=1 -> s_pred_o=0.
REQ-041 Priority: s_fencei_i in SUSPEND -> INVAL the next cycle, then ACTIVE. s_fencei_i with s_cfg_en_i=0 -> INVAL, then OFF.
REQ-042 Saturation: force 65535 suspensions (or preload the counter) -> a further suspension leaves s_suspend_cnt_o=16'hFFFF.
